// File: rtl/ml_pkg.sv
// Shared definitions for the systolic network cells: result encoding and the read FSM states.
package ml_pkg;

    localparam int ML_DATA_WIDTH    = 32;
    localparam int RESULT_VALID_BIT = ML_DATA_WIDTH;

    localparam logic [ML_DATA_WIDTH:0] EMPTY_RESULT = {1'b0, {ML_DATA_WIDTH{1'b0}}};

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } rd_state_e;

endpackage

// File: rtl/input_stream_cell_if.sv
// Upstream element handshake of input_stream_cell: master offers elements, slave accepts them.
interface input_stream_cell_if #(
    parameter int DATA_WIDTH = 32
) ();

    logic [DATA_WIDTH-1:0] in_value;
    logic                  in_valid;
    logic                  in_ready;

    modport master (
        output in_value,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_value,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/input_slot_buffer.sv
// Vector slot storage for input_stream_cell: one synchronous write port, one combinational read port.
module input_slot_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = 3
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Element write on accepted handshake.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/input_stream_cell.sv
// Input stage of the systolic network: buffers whole vectors and replays them as index/value streams.
// Optional feature macro: INPUT_STREAM_COUNT_EN adds the vector_count output.
module input_stream_cell
    import ml_pkg::*;
#(
    parameter int DATA_WIDTH    = ML_DATA_WIDTH,
    parameter int WEIGHT_AMOUNT = 4,
    parameter int VECTOR_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input_stream_cell_if.slave    in_if,
    output logic [DATA_WIDTH-1:0] output_index,
    output logic [DATA_WIDTH-1:0] output_value,
    output logic [DATA_WIDTH:0]   output_result,
    output logic                  output_enable
`ifdef INPUT_STREAM_COUNT_EN
    ,
    output logic [DATA_WIDTH-1:0] vector_count
`endif
);

    localparam int POS_W  = (WEIGHT_AMOUNT > 1) ? $clog2(WEIGHT_AMOUNT) : 1;
    localparam int SLOT_W = $clog2(VECTOR_DEPTH);
    localparam int DEPTH  = VECTOR_DEPTH * WEIGHT_AMOUNT;
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [POS_W-1:0]  LAST_POS  = POS_W'(WEIGHT_AMOUNT - 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(VECTOR_DEPTH - 1);

    function automatic logic [SLOT_W-1:0] slot_inc(input logic [SLOT_W-1:0] s);
        if (s == LAST_SLOT) begin
            return {SLOT_W{1'b0}};
        end else begin
            return s + SLOT_W'(1);
        end
    endfunction

    function automatic logic [ADDR_W-1:0] slot_addr(input logic [SLOT_W-1:0] s,
                                                     input logic [POS_W-1:0]  p);
        return ADDR_W'(s) * ADDR_W'(WEIGHT_AMOUNT) + ADDR_W'(p);
    endfunction

    logic [SLOT_W-1:0]     wr_slot_q, wr_slot_d;
    logic [POS_W-1:0]      wr_pos_q, wr_pos_d;
    logic [SLOT_W-1:0]     rd_slot_q, rd_slot_d;
    logic [POS_W-1:0]      rd_pos_q, rd_pos_d;
    logic [VECTOR_DEPTH-1:0] full_q, full_d;
    rd_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] index_q, index_d;
    logic [DATA_WIDTH-1:0] value_q, value_d;
    logic                  enable_q, enable_d;

    logic                  in_ready_s;
    logic                  accept_s;
    logic                  set_full_s;
    logic                  clr_full_s;
    logic                  last_out_s;
    logic                  emit_s;
    logic [DATA_WIDTH-1:0] rd_data_s;

`ifdef INPUT_STREAM_COUNT_EN
    logic [DATA_WIDTH-1:0] count_q, count_d;
`endif

    input_slot_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_buf (
        .clk     (clk),
        .wr_en   (accept_s),
        .wr_addr (slot_addr(wr_slot_q, wr_pos_q)),
        .wr_data (in_if.in_value),
        .rd_addr (slot_addr(rd_slot_q, rd_pos_q)),
        .rd_data (rd_data_s)
    );

    // Write side: accept elements and mark a slot full when its last position lands.
    always_comb begin
        in_ready_s = ~full_q[wr_slot_q];
        accept_s   = in_if.in_valid & in_ready_s;
        wr_pos_d   = wr_pos_q;
        wr_slot_d  = wr_slot_q;
        set_full_s = 1'b0;
        if (accept_s) begin
            if (wr_pos_q == LAST_POS) begin
                wr_pos_d   = {POS_W{1'b0}};
                wr_slot_d  = slot_inc(wr_slot_q);
                set_full_s = 1'b1;
            end else begin
                wr_pos_d   = wr_pos_q + POS_W'(1);
            end
        end else begin
            wr_pos_d = wr_pos_q;
        end
    end

    assign in_if.in_ready = in_ready_s;

    // Read FSM: IDLE already emits element 0 on its exit edge so a vector follows its last write by one edge.
    always_comb begin
        state_d    = state_q;
        rd_slot_d  = rd_slot_q;
        rd_pos_d   = rd_pos_q;
        index_d    = index_q;
        value_d    = value_q;
        enable_d   = 1'b0;
        clr_full_s = 1'b0;
        last_out_s = 1'b0;
        case (state_q)
            IDLE:    emit_s = full_q[rd_slot_q];
            STREAM:  emit_s = 1'b1;
            default: emit_s = 1'b0;
        endcase
        if (emit_s) begin
            index_d  = DATA_WIDTH'(rd_pos_q);
            value_d  = rd_data_s;
            enable_d = 1'b1;
            if (rd_pos_q == LAST_POS) begin
                clr_full_s = 1'b1;
                last_out_s = 1'b1;
                rd_pos_d   = {POS_W{1'b0}};
                rd_slot_d  = slot_inc(rd_slot_q);
                state_d    = full_q[slot_inc(rd_slot_q)] ? STREAM : IDLE;
            end else begin
                rd_pos_d   = rd_pos_q + POS_W'(1);
                state_d    = STREAM;
            end
        end else begin
            state_d = IDLE;
        end
    end

    // Slot flags: writer and reader never touch the same slot on one edge, so both updates apply.
    always_comb begin
        full_d = full_q;
        if (clr_full_s) begin
            full_d[rd_slot_q] = 1'b0;
        end else begin
            full_d[rd_slot_q] = full_q[rd_slot_q];
        end
        if (set_full_s) begin
            full_d[wr_slot_q] = 1'b1;
        end else begin
            full_d[wr_slot_q] = full_d[wr_slot_q];
        end
    end

`ifdef INPUT_STREAM_COUNT_EN
    // Completed-vector counter; wraps silently.
    always_comb begin
        if (last_out_s) begin
            count_d = count_q + DATA_WIDTH'(1);
        end else begin
            count_d = count_q;
        end
    end
`endif

    // State, pointer and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_slot_q <= {SLOT_W{1'b0}};
            wr_pos_q  <= {POS_W{1'b0}};
            rd_slot_q <= {SLOT_W{1'b0}};
            rd_pos_q  <= {POS_W{1'b0}};
            full_q    <= {VECTOR_DEPTH{1'b0}};
            state_q   <= IDLE;
            index_q   <= {DATA_WIDTH{1'b0}};
            value_q   <= {DATA_WIDTH{1'b0}};
            enable_q  <= 1'b0;
`ifdef INPUT_STREAM_COUNT_EN
            count_q   <= {DATA_WIDTH{1'b0}};
`endif
        end else begin
            wr_slot_q <= wr_slot_d;
            wr_pos_q  <= wr_pos_d;
            rd_slot_q <= rd_slot_d;
            rd_pos_q  <= rd_pos_d;
            full_q    <= full_d;
            state_q   <= state_d;
            index_q   <= index_d;
            value_q   <= value_d;
            enable_q  <= enable_d;
`ifdef INPUT_STREAM_COUNT_EN
            count_q   <= count_d;
`endif
        end
    end

    assign output_index  = index_q;
    assign output_value  = value_q;
    assign output_enable = enable_q;
    assign output_result = (DATA_WIDTH + 1)'(EMPTY_RESULT);
`ifdef INPUT_STREAM_COUNT_EN
    assign vector_count  = count_q;
`endif

endmodule

// File: tb/tb_input_stream_cell.sv
// Directed self-checking bench for input_stream_cell (also covers INPUT_STREAM_COUNT_EN when defined).
module tb_input_stream_cell;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] output_index;
    logic [31:0] output_value;
    logic [32:0] output_result;
    logic        output_enable;
`ifdef INPUT_STREAM_COUNT_EN
    logic [31:0] vector_count;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] src_q[$];
    logic [31:0] out_idx_q[$];
    logic [31:0] out_val_q[$];
    logic [31:0] cnt_q[$];
    bit          en_hist[$];
    bit          rdy_hist[$];

    input_stream_cell_if #(.DATA_WIDTH(32)) in_if ();

    input_stream_cell dut (
        .clk           (clk),
        .rst           (rst),
        .in_if         (in_if),
        .output_index  (output_index),
        .output_value  (output_value),
        .output_result (output_result),
        .output_enable (output_enable)
`ifdef INPUT_STREAM_COUNT_EN
        ,
        .vector_count  (vector_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_if.in_valid = 1'b0;
        in_if.in_value = 32'h0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic clear_mon();
        src_q.delete();
        out_idx_q.delete();
        out_val_q.delete();
        cnt_q.delete();
        en_hist.delete();
        rdy_hist.delete();
    endtask

    // Drives src_q elements whenever offered and records everything the DUT emits.
    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            logic vld;
            logic rdy;
            vld = (src_q.size() > 0);
            in_if.in_valid = vld;
            in_if.in_value = vld ? src_q[0] : 32'h0;
            rdy = in_if.in_ready;
            rdy_hist.push_back(rdy);
            step();
            if (vld && rdy) void'(src_q.pop_front());
            en_hist.push_back(output_enable);
            if (output_enable) begin
                out_idx_q.push_back(output_index);
                out_val_q.push_back(output_value);
`ifdef INPUT_STREAM_COUNT_EN
                if (output_index == 32'd3) cnt_q.push_back(vector_count);
`endif
            end
        end
        in_if.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (output_enable !== 1'b0) begin
            errors++; $display("FAIL reset_enable: got %0b expected 0", output_enable);
        end
        checks++;
        if (output_index !== 32'd0 || output_value !== 32'd0) begin
            errors++; $display("FAIL reset_data: got idx %0d val %0d expected 0 0", output_index, output_value);
        end
        checks++;
        if (output_result !== 33'd0) begin
            errors++; $display("FAIL reset_result: got %0h expected 0", output_result);
        end
        checks++;
        if (in_if.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %0b expected 1", in_if.in_ready);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        clear_mon();
        for (int i = 0; i < 4; i++) src_q.push_back(32'd1);
        for (int i = 0; i < 4; i++) src_q.push_back(32'd2);
        run(14);
        checks++;
        if (out_idx_q.size() != 8) begin
            errors++; $display("FAIL b2b_count: got %0d elements expected 8", out_idx_q.size());
        end
        for (int i = 0; i < 8; i++) begin
            logic [31:0] ev;
            ev = (i < 4) ? 32'd1 : 32'd2;
            checks++;
            if (i >= out_idx_q.size() || out_idx_q[i] !== 32'(i % 4) || out_val_q[i] !== ev) begin
                errors++; $display("FAIL b2b_elem%0d: got idx %0d val %0d expected idx %0d val %0d",
                                   i, (i < out_idx_q.size()) ? out_idx_q[i] : 32'hFFFF_FFFF,
                                   (i < out_val_q.size()) ? out_val_q[i] : 32'hFFFF_FFFF, i % 4, ev);
            end
        end
        // Elements land on edges 1..8, so enable is high after edges 5..12 with no hole.
        for (int c = 3; c <= 12; c++) begin
            bit ee;
            ee = (c >= 4 && c <= 11);
            checks++;
            if (en_hist[c] !== ee) begin
                errors++; $display("FAIL b2b_enable_cyc%0d: got %0b expected %0b", c, en_hist[c], ee);
            end
        end
    endtask

    task automatic test_latency();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            in_if.in_valid = 1'b1;
            in_if.in_value = 32'(10 + i);
            step();
        end
        in_if.in_valid = 1'b0;
        checks++;
        if (output_enable !== 1'b0) begin
            errors++; $display("FAIL lat_early: got enable %0b expected 0", output_enable);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (output_enable !== 1'b1 || output_index !== 32'(k) || output_value !== 32'(10 + k)) begin
                errors++; $display("FAIL lat_elem%0d: got en %0b idx %0d val %0d expected en 1 idx %0d val %0d",
                                   k, output_enable, output_index, output_value, k, 10 + k);
            end
        end
        step();
        checks++;
        if (output_enable !== 1'b0) begin
            errors++; $display("FAIL lat_end: got enable %0b expected 0", output_enable);
        end
    endtask

    task automatic test_backpressure();
        int rdy_low;
        do_reset();
        clear_mon();
        for (int i = 0; i < 12; i++) src_q.push_back(32'(100 + i));
        run(24);
        checks++;
        if (out_idx_q.size() != 12 || src_q.size() != 0) begin
            errors++; $display("FAIL bp_count: got %0d out %0d left expected 12 0", out_idx_q.size(), src_q.size());
        end
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (i >= out_val_q.size() || out_idx_q[i] !== 32'(i % 4) || out_val_q[i] !== 32'(100 + i)) begin
                errors++; $display("FAIL bp_elem%0d: got val %0d expected idx %0d val %0d",
                                   i, (i < out_val_q.size()) ? out_val_q[i] : 32'hFFFF_FFFF, i % 4, 100 + i);
            end
        end
        // The reader frees a slot on the same edge the writer fills the other, so ready never drops here.
        rdy_low = 0;
        for (int c = 0; c < 12; c++) if (rdy_hist[c] !== 1'b1) rdy_low++;
        checks++;
        if (rdy_low != 0) begin
            errors++; $display("FAIL bp_ready: got %0d not-ready cycles expected 0", rdy_low);
        end
    endtask

    task automatic test_partial();
        int en_seen;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            in_if.in_valid = 1'b1;
            in_if.in_value = 32'(20 + i);
            step();
        end
        in_if.in_valid = 1'b0;
        en_seen = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (output_enable !== 1'b0) en_seen++;
        end
        checks++;
        if (en_seen != 0) begin
            errors++; $display("FAIL partial_idle: got %0d enabled cycles expected 0", en_seen);
        end
        in_if.in_valid = 1'b1;
        in_if.in_value = 32'd23;
        step();
        in_if.in_valid = 1'b0;
        checks++;
        if (output_enable !== 1'b0) begin
            errors++; $display("FAIL partial_early: got enable %0b expected 0", output_enable);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (output_enable !== 1'b1 || output_index !== 32'(k) || output_value !== 32'(20 + k)) begin
                errors++; $display("FAIL partial_elem%0d: got en %0b idx %0d val %0d expected en 1 idx %0d val %0d",
                                   k, output_enable, output_index, output_value, k, 20 + k);
            end
        end
    endtask

    task automatic test_reset_mid();
        int en_seen;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            in_if.in_valid = 1'b1;
            in_if.in_value = (i < 4) ? 32'(50 + i) : 32'(56 + i);
            step();
        end
        in_if.in_valid = 1'b0;
        step();
        checks++;
        if (output_enable !== 1'b1 || output_index !== 32'd2 || output_value !== 32'd52) begin
            errors++; $display("FAIL rmid_pre: got en %0b idx %0d val %0d expected en 1 idx 2 val 52",
                               output_enable, output_index, output_value);
        end
        rst = 1'b1;
        step();
        checks++;
        if (output_enable !== 1'b0 || output_index !== 32'd0 || output_value !== 32'd0 || output_result !== 33'd0) begin
            errors++; $display("FAIL rmid_zero: got en %0b idx %0d val %0d res %0h expected all 0",
                               output_enable, output_index, output_value, output_result);
        end
        rst = 1'b0;
        checks++;
        if (in_if.in_ready !== 1'b1) begin
            errors++; $display("FAIL rmid_ready: got %0b expected 1", in_if.in_ready);
        end
        en_seen = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (output_enable !== 1'b0) en_seen++;
        end
        checks++;
        if (en_seen != 0) begin
            errors++; $display("FAIL rmid_flushed: got %0d enabled cycles expected 0", en_seen);
        end
        for (int i = 0; i < 4; i++) begin
            in_if.in_valid = 1'b1;
            in_if.in_value = 32'(70 + i);
            step();
        end
        in_if.in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (output_enable !== 1'b1 || output_index !== 32'(k) || output_value !== 32'(70 + k)) begin
                errors++; $display("FAIL rmid_fresh%0d: got en %0b idx %0d val %0d expected en 1 idx %0d val %0d",
                                   k, output_enable, output_index, output_value, k, 70 + k);
            end
        end
    endtask

`ifdef INPUT_STREAM_COUNT_EN
    task automatic test_count();
        do_reset();
        clear_mon();
        checks++;
        if (vector_count !== 32'd0) begin
            errors++; $display("FAIL cnt_reset: got %0d expected 0", vector_count);
        end
        for (int i = 0; i < 12; i++) src_q.push_back(32'(200 + i));
        run(24);
        for (int v = 0; v < 3; v++) begin
            checks++;
            if (v >= cnt_q.size() || cnt_q[v] !== 32'(v + 1)) begin
                errors++; $display("FAIL cnt_vec%0d: got %0d expected %0d",
                                   v, (v < cnt_q.size()) ? cnt_q[v] : 32'hFFFF_FFFF, v + 1);
            end
        end
        checks++;
        if (vector_count !== 32'd3) begin
            errors++; $display("FAIL cnt_final: got %0d expected 3", vector_count);
        end
        do_reset();
        checks++;
        if (vector_count !== 32'd0) begin
            errors++; $display("FAIL cnt_clear: got %0d expected 0", vector_count);
        end
    endtask
`endif

    initial begin
        in_if.in_valid = 1'b0;
        in_if.in_value = 32'h0;
        test_reset();
        test_back_to_back();
        test_latency();
        test_backpressure();
        test_partial();
        test_reset_mid();
`ifdef INPUT_STREAM_COUNT_EN
        test_count();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
